servo_pwm_multi: RTL and testbench

//  N-channel servo PWM generator with an AXI4-Lite slave register file; next generation of the single-channel servo IP.

---
 rtl/servo_pwm_pkg.sv | 52 +++++
 rtl/servo_pwm_channel.sv | 56 +++++
 rtl/servo_pwm_multi.sv | 202 ++++++++++++++++++++
 tb/tb_servo_pwm_multi.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared constants and helpers for the multi-channel servo PWM.
// Optional feature macro: SERVO_PWM_RAMP_EN (enables the RAMP register and ramped pulse updates).
package servo_pwm_pkg;

    // Register byte offsets on the AXI-Lite slave
    localparam int unsigned OFS_CTRL       = 'h00;
    localparam int unsigned OFS_PERIOD     = 'h04;
    localparam int unsigned OFS_STATUS     = 'h08;
    localparam int unsigned OFS_RAMP       = 'h0C;
    localparam int unsigned OFS_PULSE_BASE = 'h10;

    localparam logic [1:0]  RESP_OKAY  = 2'b00;
    localparam int unsigned PERIOD_MIN = 2;

    // Defaults: 20 ms period and 1.5 ms pulse at 100 MHz
    localparam int unsigned PERIOD_RST_DEF = 2000000;
    localparam int unsigned PULSE_RST_DEF  = 150000;

    // Write-channel FSM states
    localparam logic [1:0] WR_IDLE = 2'd0;
    localparam logic [1:0] WR_ACK  = 2'd1;
    localparam logic [1:0] WR_RESP = 2'd2;

    // Read-channel FSM states
    localparam logic [1:0] RD_IDLE = 2'd0;
    localparam logic [1:0] RD_ACK  = 2'd1;
    localparam logic [1:0] RD_DATA = 2'd2;

    // Merge a write word into the old register value byte by byte
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    // Move cur toward tgt by at most step; step 0 means jump straight to tgt
    function automatic logic [31:0] ramp_toward(input logic [31:0] cur,
                                                input logic [31:0] tgt,
                                                input logic [31:0] step);
        logic [31:0] diff;
        logic [31:0] stp;
        diff = (tgt >= cur) ? (tgt - cur) : (cur - tgt);
        stp  = ((step == 32'd0) || (step > diff)) ? diff : step;
        return (tgt >= cur) ? (cur + stp) : (cur - stp);
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// servo_pwm_channel: one PWM channel. Holds the shadow enable and pulse width that
// only change at period wrap, and registers the compare result onto the pin.
// With SERVO_PWM_RAMP_EN the shadow pulse walks toward the target by the ramp step.
module servo_pwm_channel
    import servo_pwm_pkg::*;
#(
    parameter int CNT_WIDTH = 24,
    parameter int PULSE_RST = 150000
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SERVO_PWM_RAMP_EN
    input  logic [CNT_WIDTH-1:0] ramp,
`endif
    input  logic                 wrap,
    input  logic                 en_reg,
    input  logic [CNT_WIDTH-1:0] pulse_reg,
    input  logic [CNT_WIDTH-1:0] cnt,
    output logic                 pwm
);

    logic                 en_sh_q, en_sh_d;
    logic [CNT_WIDTH-1:0] pulse_sh_q, pulse_sh_d;
    logic                 pwm_q, pwm_d;

    // Shadow update at wrap and compare against the shared counter
    always_comb begin
        en_sh_d    = en_sh_q;
        pulse_sh_d = pulse_sh_q;
        if (wrap) begin
            en_sh_d = en_reg;
`ifdef SERVO_PWM_RAMP_EN
            pulse_sh_d = CNT_WIDTH'(ramp_toward(32'(pulse_sh_q), 32'(pulse_reg), 32'(ramp)));
`else
            pulse_sh_d = pulse_reg;
`endif
        end
        pwm_d = en_sh_q & (cnt < pulse_sh_q);
    end

    // Channel state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            en_sh_q    <= 1'b0;
            pulse_sh_q <= CNT_WIDTH'(PULSE_RST);
            pwm_q      <= 1'b0;
        end else begin
            en_sh_q    <= en_sh_d;
            pulse_sh_q <= pulse_sh_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: N-channel servo PWM generator with an AXI4-Lite register file.
// A shared counter runs 0..per_sh-1; period, enables and pulse widths are latched
// into shadows only at the wrap so a period is never cut short or stretched.
// Optional feature macro: SERVO_PWM_RAMP_EN (RAMP register at 0x0C, ramped pulse changes).
// Handshake: a beat transfers on a rising edge where VALID and READY are both high;
// masters hold VALID and payload until that edge, the slave holds BVALID/RVALID and
// their payload until BREADY/RREADY is seen high on an edge.
module servo_pwm_multi
    import servo_pwm_pkg::*;
#(
    parameter int NUM_CH             = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH          = 24,
    parameter int PERIOD_RST         = PERIOD_RST_DEF,
    parameter int PULSE_RST          = PULSE_RST_DEF
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_CH-1:0]               pwm_out,
    output logic                            period_tick,
    output logic [3:0]                      dbg_fsm_state
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int CW = CNT_WIDTH;

    logic [1:0]        wr_state_q, wr_state_d;
    logic [1:0]        rd_state_q, rd_state_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [NUM_CH-1:0] ctrl_q, ctrl_d;
    logic [CW-1:0]     period_q, period_d;
    logic [CW-1:0]     pulse_q [NUM_CH];
    logic [CW-1:0]     pulse_d [NUM_CH];
`ifdef SERVO_PWM_RAMP_EN
    logic [CW-1:0]     ramp_q, ramp_d;
`endif
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     per_sh_q, per_sh_d;
    logic              tick_q, tick_d;
    logic              wrap;
    logic              wr_en;
    logic [31:0]       wr_word;

    // Register read mux; unmapped offsets and unused upper bits return 0
    function automatic logic [31:0] reg_value(input logic [AW-1:0] addr);
        logic [31:0] v;
        v = '0;
        if (addr == AW'(OFS_CTRL))   v = 32'(ctrl_q);
        if (addr == AW'(OFS_PERIOD)) v = 32'(period_q);
        if (addr == AW'(OFS_STATUS)) v = 32'(cnt_q);
`ifdef SERVO_PWM_RAMP_EN
        if (addr == AW'(OFS_RAMP))   v = 32'(ramp_q);
`endif
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr == AW'(OFS_PULSE_BASE + 4 * i)) v = 32'(pulse_q[i]);
        end
        return v;
    endfunction

    // Write channel FSM: idle -> ready pulse (register written) -> response
    always_comb begin
        wr_state_d = wr_state_q;
        wr_en      = 1'b0;
        case (wr_state_q)
            WR_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID) wr_state_d = WR_ACK;
            WR_ACK: begin
                wr_en      = 1'b1;
                wr_state_d = WR_RESP;
            end
            WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Register file update on the write handshake edge, byte-masked by WSTRB
    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        pulse_d  = pulse_q;
`ifdef SERVO_PWM_RAMP_EN
        ramp_d   = ramp_q;
`endif
        wr_word  = apply_wstrb(reg_value(S_AXI_AWADDR), 32'(S_AXI_WDATA), 4'(S_AXI_WSTRB));
        if (wr_en) begin
            if (S_AXI_AWADDR == AW'(OFS_CTRL)) ctrl_d = wr_word[NUM_CH-1:0];
            if (S_AXI_AWADDR == AW'(OFS_PERIOD)) begin
                period_d = (wr_word[CW-1:0] < CW'(PERIOD_MIN)) ? CW'(PERIOD_MIN) : wr_word[CW-1:0];
            end
`ifdef SERVO_PWM_RAMP_EN
            if (S_AXI_AWADDR == AW'(OFS_RAMP)) ramp_d = wr_word[CW-1:0];
`endif
            for (int i = 0; i < NUM_CH; i++) begin
                if (S_AXI_AWADDR == AW'(OFS_PULSE_BASE + 4 * i)) pulse_d[i] = wr_word[CW-1:0];
            end
        end
    end

    // Read channel FSM: idle -> ready pulse (data captured) -> data held until RREADY
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            RD_IDLE: if (S_AXI_ARVALID) rd_state_d = RD_ACK;
            RD_ACK: begin
                rdata_d    = reg_value(S_AXI_ARADDR);
                rd_state_d = RD_DATA;
            end
            RD_DATA: if (S_AXI_RREADY) begin
                rdata_d    = '0;
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Shared period counter; shadow period reloads only at the wrap
    always_comb begin
        wrap     = (cnt_q == per_sh_q - 1'b1);
        cnt_d    = wrap ? '0 : cnt_q + 1'b1;
        per_sh_d = wrap ? period_q : per_sh_q;
        tick_d   = wrap;
    end

    // State registers with synchronous reset
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            ctrl_q     <= '0;
            period_q   <= CW'(PERIOD_RST);
            for (int i = 0; i < NUM_CH; i++) pulse_q[i] <= CW'(PULSE_RST);
`ifdef SERVO_PWM_RAMP_EN
            ramp_q     <= '0;
`endif
            cnt_q      <= '0;
            per_sh_q   <= CW'(PERIOD_RST);
            tick_q     <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            pulse_q    <= pulse_d;
`ifdef SERVO_PWM_RAMP_EN
            ramp_q     <= ramp_d;
`endif
            cnt_q      <= cnt_d;
            per_sh_q   <= per_sh_d;
            tick_q     <= tick_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        servo_pwm_channel #(
            .CNT_WIDTH(CNT_WIDTH),
            .PULSE_RST(PULSE_RST)
        ) u_ch (
            .clk      (ACLK),
            .rst      (ARESET),
`ifdef SERVO_PWM_RAMP_EN
            .ramp     (ramp_q),
`endif
            .wrap     (wrap),
            .en_reg   (ctrl_q[g]),
            .pulse_reg(pulse_q[g]),
            .cnt      (cnt_q),
            .pwm      (pwm_out[g])
        );
    end

    assign S_AXI_AWREADY = (wr_state_q == WR_ACK);
    assign S_AXI_WREADY  = (wr_state_q == WR_ACK);
    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = (rd_state_q == RD_ACK);
    assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(rdata_q);
    assign S_AXI_RRESP   = RESP_OKAY;
    assign period_tick   = tick_q;
    assign dbg_fsm_state = {rd_state_q, wr_state_q};

endmodule

// File: tb/tb_servo_pwm_multi.sv
// tb_servo_pwm_multi: directed bench for servo_pwm_multi with a short reset period
// so several periods fit in a brief run. Register reads and per-period pulse
// measurements are checked against expected values queued when stimulus is issued.
module tb_servo_pwm_multi;

    localparam int NUM_CH  = 4;
    localparam int PER_RST = 300;
    localparam int PUL_RST = 150000;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_PERIOD = 6'h04;
    localparam logic [5:0] A_STATUS = 6'h08;
    localparam logic [5:0] A_RAMP   = 6'h0C;
    localparam logic [5:0] A_P0     = 6'h10;
    localparam logic [5:0] A_P1     = 6'h14;
    localparam logic [5:0] A_P2     = 6'h18;
    localparam logic [5:0] A_P3     = 6'h1C;
    localparam logic [5:0] A_NONE   = 6'h20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [5:0]        awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [5:0]        araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NUM_CH-1:0] pwm_out;
    logic              period_tick;
    logic [3:0]        dbg_fsm_state;

    servo_pwm_multi #(
        .NUM_CH    (NUM_CH),
        .PERIOD_RST(PER_RST),
        .PULSE_RST (PUL_RST)
    ) dut (
        .ACLK         (clk),
        .ARESET       (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .pwm_out      (pwm_out),
        .period_tick  (period_tick),
        .dbg_fsm_state(dbg_fsm_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    int hi_cnt[NUM_CH];
    int rise0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_no_expect"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int hold);
        int n;
        logic stable;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
        if (!awready) begin
            check("aw_timeout", 32'(awready), 32'd1);
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (!wready) check("wready_with_awready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!bvalid) begin
            check("b_timeout", 32'(bvalid), 32'd1);
            return;
        end
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!bvalid || bresp !== 2'b00) stable = 1'b0;
            end
            check("bvalid_held", 32'(stable), 32'd1);
            check("bresp_okay", 32'(bresp), 32'd0);
        end
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read_raw(input logic [5:0] a, input int hold, output logic [31:0] d);
        int n;
        logic stable;
        d = 32'hDEAD_DEAD;
        araddr = a; arvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
        if (!arready) begin
            check("ar_timeout", 32'(arready), 32'd1);
            arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rvalid) begin
            check("r_timeout", 32'(rvalid), 32'd1);
            return;
        end
        d = rdata;
        if (hold > 0) begin
            stable = 1'b1;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!rvalid || rdata !== d) stable = 1'b0;
            end
            check("rvalid_rdata_held", 32'(stable), 32'd1);
            check("rresp_okay", 32'(rresp), 32'd0);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] a, input logic [31:0] exp,
                            input string tag, input int hold);
        logic [31:0] d;
        exp_q.push_back(exp);
        axi_read_raw(a, hold, d);
        check_pop(tag, d);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!period_tick && n < 2000);
        if (!period_tick) check("tick_timeout", 32'(period_tick), 32'd1);
    endtask

    // Count high samples over one period; call while period_tick is visible
    task automatic measure_window(input int per);
        logic prev;
        for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
        rise0 = 0;
        prev  = pwm_out[0];
        for (int k = 0; k < per; k++) begin
            @(posedge clk); #1;
            for (int c = 0; c < NUM_CH; c++) if (pwm_out[c]) hi_cnt[c]++;
            if (pwm_out[0] && !prev) rise0++;
            prev = pwm_out[0];
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] s1, s2;
        logic [31:0] ramp_exp[5];
        int n;
        logic any_pwm;

        repeat (5) @(posedge clk);
        #1;
        check("rst_pwm_out", 32'(pwm_out), 32'd0);
        check("rst_tick", 32'(period_tick), 32'd0);
        check("rst_ready_valid", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;

        // Reset defaults, counter running, tick spacing, outputs idle
        axi_read(A_CTRL, 32'd0, "rd_ctrl_rst", 0);
        axi_read(A_PERIOD, 32'(PER_RST), "rd_period_rst", 0);
        axi_read(A_P0, 32'(PUL_RST), "rd_pulse0_rst", 0);
        axi_read_raw(A_STATUS, 0, s1);
        repeat (10) @(posedge clk);
        #1;
        axi_read_raw(A_STATUS, 0, s2);
        check("status_increases", 32'(s2 > s1 && s2 < PER_RST), 32'd1);
        wait_tick();
        n = 0;
        any_pwm = 1'b0;
        do begin
            @(posedge clk); #1; n++;
            if (pwm_out != '0) any_pwm = 1'b1;
        end while (!period_tick && n < 1000);
        check("tick_spacing", 32'(n), 32'(PER_RST));
        check("pwm_idle_ctrl0", 32'(any_pwm), 32'd0);

        // Channel 0 at 25/100
        axi_write(A_PERIOD, 32'd100, 4'hF, 0);
        axi_write(A_P0, 32'd25, 4'hF, 0);
        axi_write(A_CTRL, 32'd1, 4'hF, 0);
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd0);
        wait_tick();
        measure_window(100);
        check_pop("ch0_high_25", 32'(hi_cnt[0]));
        check_pop("ch1to3_low", 32'(hi_cnt[1] + hi_cnt[2] + hi_cnt[3]));

        // Pulse 0 stays low, pulse beyond period stays high
        axi_write(A_P1, 32'd0, 4'hF, 0);
        axi_write(A_P2, 32'd200, 4'hF, 0);
        axi_write(A_CTRL, 32'h7, 4'hF, 0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd100);
        exp_q.push_back(32'd25);
        wait_tick();
        measure_window(100);
        check_pop("ch1_pulse0_low", 32'(hi_cnt[1]));
        check_pop("ch2_pulse200_high", 32'(hi_cnt[2]));
        check_pop("ch0_still_25", 32'(hi_cnt[0]));

        // Mid-period change 25 -> 60 does not touch the current period
        wait_tick();
        exp_q.push_back(32'd25);
        exp_q.push_back(32'd1);
        fork
            measure_window(100);
            begin
                repeat (10) @(posedge clk);
                #1;
                axi_write(A_P0, 32'd60, 4'hF, 0);
            end
        join
        check_pop("midper_current_25", 32'(hi_cnt[0]));
        check_pop("midper_single_pulse", 32'(rise0));
        exp_q.push_back(32'd60);
        exp_q.push_back(32'd1);
        measure_window(100);
        check_pop("next_period_60", 32'(hi_cnt[0]));
        check_pop("next_single_pulse", 32'(rise0));

        // Ramp behaviour (or direct jump without the ramp feature)
        axi_write(A_P0, 32'd25, 4'hF, 0);
        wait_tick();
        exp_q.push_back(32'd25);
        fork
            measure_window(100);
            begin
                repeat (10) @(posedge clk);
                #1;
                axi_write(A_RAMP, 32'd10, 4'hF, 0);
                axi_write(A_P0, 32'd60, 4'hF, 0);
            end
        join
        check_pop("ramp_start_25", 32'(hi_cnt[0]));
`ifdef SERVO_PWM_RAMP_EN
        ramp_exp = '{32'd35, 32'd45, 32'd55, 32'd60, 32'd60};
`else
        ramp_exp = '{32'd60, 32'd60, 32'd60, 32'd60, 32'd60};
`endif
        for (int p = 0; p < 5; p++) begin
            exp_q.push_back(ramp_exp[p]);
            measure_window(100);
            check_pop($sformatf("ramp_period_%0d", p), 32'(hi_cnt[0]));
        end
`ifdef SERVO_PWM_RAMP_EN
        axi_read(A_RAMP, 32'd10, "rd_ramp", 0);
`else
        axi_read(A_RAMP, 32'd0, "rd_0x0c_unmapped", 0);
`endif

        // AXI details: byte strobe, held responses, concurrency, clipping
        axi_write(A_P3, 32'hDEADBEEF, 4'b0001, 10);
        axi_read(A_P3, 32'h0249EF, "rd_pulse3_wstrb", 10);
        fork
            axi_write(A_P1, 32'h123, 4'hF, 0);
            axi_read(A_PERIOD, 32'd100, "rd_period_concurrent", 0);
        join
        axi_read(A_P1, 32'h123, "rd_pulse1_after_concurrent", 0);
        axi_write(A_NONE, 32'hFFFF_FFFF, 4'hF, 0);
        axi_read(A_NONE, 32'd0, "rd_unmapped", 0);
        axi_write(A_CTRL, 32'hFF, 4'hF, 0);
        axi_read(A_CTRL, 32'hF, "rd_ctrl_masked", 0);
        axi_write(A_PERIOD, 32'h1234_5678, 4'hF, 0);
        axi_read(A_PERIOD, 32'h34_5678, "rd_period_24bit", 0);
        axi_write(A_PERIOD, 32'd1, 4'hF, 0);
        axi_read(A_PERIOD, 32'd2, "rd_period_min", 0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
